// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Round-robin sharing of one Uart8 transmitter between         |
// |               NUM_REQ byte producers, with a start watchdog.               |
// |               Optional packet lock: define UART_ARB_LOCK_EN.               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int START_WAIT = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]   reqLast,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   reqDone,
    output logic [NUM_REQ-1:0]   reqErr,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txByte,
    input  logic                 txBusy,
    input  logic                 txDone,
    output logic                 arbIdle
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_wd_w  = (START_WAIT > 2) ? $clog2(START_WAIT) : 1;
    localparam logic [c_wd_w-1:0]  c_wd_max   = c_wd_w'(START_WAIT - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_init = c_ptr_w'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_ptr_w-1:0]   r_ptr, w_ptr_nxt;
    logic [c_ptr_w-1:0]   r_owner, w_owner_nxt;
    logic [c_wd_w-1:0]    r_wdog, w_wdog_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]   r_ready, w_ready_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic [NUM_REQ-1:0]   r_err, w_err_nxt;
    logic                 r_tx_en;
    logic                 r_tx_start, w_start_nxt;
    logic [7:0]           r_tx_byte, w_byte_nxt;

    logic [NUM_REQ-1:0]   w_req_eff;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_win;
    logic [c_ptr_w-1:0]   w_cand;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [7:0]           w_win_data;

`ifdef UART_ARB_LOCK_EN
    logic r_lock, w_lock_nxt;
    logic r_last, w_last_nxt;

    // While locked only the current owner may be re-granted.
    assign w_req_eff = r_lock ? (reqValid & r_grant) : reqValid;
    assign arbIdle   = (r_state == ST_IDLE) && !r_lock;
`else
    logic w_unused_last;

    assign w_unused_last = ^reqLast;
    assign w_req_eff     = reqValid;
    assign arbIdle       = (r_state == ST_IDLE);
`endif

    // First valid request searching upward from the slot after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = c_ptr_w'((int'(r_ptr) + off) % NUM_REQ);
            if (!w_found && w_req_eff[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << w_win;
    assign w_win_data   = reqData[{w_win, 3'b000} +: 8];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_wdog_nxt  = r_wdog;
        w_grant_nxt = r_grant;
        w_ready_nxt = '0;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        w_start_nxt = r_tx_start;
        w_byte_nxt  = r_tx_byte;
`ifdef UART_ARB_LOCK_EN
        w_lock_nxt  = r_lock;
        w_last_nxt  = r_last;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_win_onehot;
                    w_owner_nxt = w_win;
                    w_ready_nxt = w_win_onehot;
                    w_byte_nxt  = w_win_data;
`ifdef UART_ARB_LOCK_EN
                    w_last_nxt  = reqLast[w_win];
`endif
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_start_nxt = 1'b1;
                w_wdog_nxt  = '0;
                w_state_nxt = ST_START;
            end
            ST_START: begin
                // A busy transmitter takes precedence over a coincident timeout.
                if (txBusy) begin
                    w_start_nxt = 1'b0;
                    w_state_nxt = ST_WAIT;
                end else if (r_wdog == c_wd_max) begin
                    w_start_nxt = 1'b0;
                    w_err_nxt   = r_grant;
                    w_ptr_nxt   = r_owner;
                    w_grant_nxt = '0;
`ifdef UART_ARB_LOCK_EN
                    w_lock_nxt  = 1'b0;
`endif
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            ST_WAIT: begin
                if (txDone) begin
                    w_done_nxt  = r_grant;
                    w_state_nxt = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
                    if (!r_last) begin
                        w_lock_nxt = 1'b1;
                    end else begin
                        w_lock_nxt  = 1'b0;
                        w_ptr_nxt   = r_owner;
                        w_grant_nxt = '0;
                    end
`else
                    w_ptr_nxt   = r_owner;
                    w_grant_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_IDLE;
            r_ptr      <= c_ptr_init;
            r_owner    <= '0;
            r_wdog     <= '0;
            r_grant    <= '0;
            r_ready    <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_tx_en    <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
`ifdef UART_ARB_LOCK_EN
            r_lock     <= 1'b0;
            r_last     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_wdog     <= w_wdog_nxt;
            r_grant    <= w_grant_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_tx_en    <= 1'b1;
            r_tx_start <= w_start_nxt;
            r_tx_byte  <= w_byte_nxt;
`ifdef UART_ARB_LOCK_EN
            r_lock     <= w_lock_nxt;
            r_last     <= w_last_nxt;
`endif
        end
    end

    assign reqReady = r_ready;
    assign reqDone  = r_done;
    assign reqErr   = r_err;
    assign grant    = r_grant;
    assign txEn     = r_tx_en;
    assign txStart  = r_tx_start;
    assign txByte   = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                           |
// | Description : Directed self-checking bench with a small Uart8 tx model.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int START_WAIT = 16;
    localparam int BIT_CLKS   = 2;

    logic                 clk = 1'b0;
    logic                 resetN;
    logic [NUM_REQ-1:0]   reqValid;
    logic [8*NUM_REQ-1:0] reqData;
    logic [NUM_REQ-1:0]   reqLast;
    logic [NUM_REQ-1:0]   reqReady;
    logic [NUM_REQ-1:0]   reqDone;
    logic [NUM_REQ-1:0]   reqErr;
    logic [NUM_REQ-1:0]   grant;
    logic                 txEn;
    logic                 txStart;
    logic [7:0]           txByte;
    logic                 txBusy;
    logic                 txDone;
    logic                 arbIdle;

    int         checks    = 0;
    int         errors    = 0;
    int         done_cnt  = 0;
    logic       uart_dead = 1'b0;
    logic [7:0] sent_q[$];
    logic [9:0] last_frame = '0;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .START_WAIT (START_WAIT)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqLast  (reqLast),
        .reqReady (reqReady),
        .reqDone  (reqDone),
        .reqErr   (reqErr),
        .grant    (grant),
        .txEn     (txEn),
        .txStart  (txStart),
        .txByte   (txByte),
        .txBusy   (txBusy),
        .txDone   (txDone),
        .arbIdle  (arbIdle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input logic [NUM_REQ-1:0] exp, input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (reqDone != '0) break;
        end
        check(tag, 32'(reqDone), 32'(exp));
    endtask

    // Uart8 transmitter model: busy two cycles after start, serial frame, done pulse.
    initial begin
        logic [9:0] bits_now;
        logic [9:0] sh;
        logic [9:0] frame_bits;
        txBusy = 1'b0;
        txDone = 1'b0;
        frame_bits = '0;
        forever begin
            @(posedge clk);
            #1;
            if (txStart && !uart_dead) begin
                repeat (2) @(posedge clk);
                #1 txBusy = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    bits_now   = {1'b1, txByte, 1'b0};
                    sh         = bits_now >> b;
                    frame_bits = {sh[0], frame_bits[9:1]};
                    repeat (BIT_CLKS) @(posedge clk);
                    #1;
                end
                sent_q.push_back(txByte);
                last_frame = frame_bits;
                txBusy = 1'b0;
                txDone = 1'b1;
                @(posedge clk);
                #1 txDone = 1'b0;
            end
        end
    end

    // Per-cycle invariants and completion count.
    always @(negedge clk) begin
        if (reqDone != '0) done_cnt++;
        check("onehot_outputs",
              32'($onehot0(grant) && $onehot0(reqReady) && $onehot0(reqDone) && $onehot0(reqErr)),
              32'd1);
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int         cnt;
        int         dsave;
        int         nready;
        logic [7:0] exp_b1;
        logic [7:0] exp_b2;

        resetN   = 1'b0;
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_grant",    32'(grant),    32'h0);
        check("rst_ready",    32'(reqReady), 32'h0);
        check("rst_done",     32'(reqDone),  32'h0);
        check("rst_err",      32'(reqErr),   32'h0);
        check("rst_txen",     32'(txEn),     32'h0);
        check("rst_txstart",  32'(txStart),  32'h0);
        check("rst_txbyte",   32'(txByte),   32'h0);
        check("rst_arbidle",  32'(arbIdle),  32'h1);
        resetN = 1'b1;
        @(negedge clk);
        check("txen_after_release", 32'(txEn), 32'h1);

        // Single requester, byte B5
        reqValid      = 4'b0001;
        reqData[7:0]  = 8'hB5;
        @(negedge clk);
        check("single_ready",   32'(reqReady), 32'h1);
        check("single_grant",   32'(grant),    32'h1);
        check("single_txbyte",  32'(txByte),   32'hB5);
        check("single_nostart", 32'(txStart),  32'h0);
        check("single_busyidle", 32'(arbIdle), 32'h0);
        reqValid     = '0;
        reqData[7:0] = 8'h00;
        @(negedge clk);
        check("single_txstart", 32'(txStart),  32'h1);
        check("single_readyoff", 32'(reqReady), 32'h0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txBusy) break;
        end
        check("start_held_until_busy", 32'(txStart), 32'h1);
        @(negedge clk);
        check("start_drop_on_busy", 32'(txStart), 32'h0);
        wait_done(4'b0001, "single_done");
        check("single_frame",   32'(last_frame), 32'h36A);
        check("single_idle",    32'(arbIdle),    32'h1);
        check("single_grant0",  32'(grant),      32'h0);

        // Reset mid-frame in WAIT
        reqValid       = 4'b0100;
        reqData[23:16] = 8'h77;
        @(negedge clk);
        check("midrst_grant", 32'(grant), 32'h4);
        reqValid = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txBusy) break;
        end
        repeat (3) @(negedge clk);
        dsave  = done_cnt;
        resetN = 1'b0;
        #1;
        check("midrst_grant0",   32'(grant),   32'h0);
        check("midrst_txstart",  32'(txStart), 32'h0);
        check("midrst_arbidle",  32'(arbIdle), 32'h1);
        repeat (40) @(negedge clk);
        check("midrst_no_done",  32'(done_cnt), 32'(dsave));
        sent_q.delete();
        resetN = 1'b1;
        @(negedge clk);

        // All four requesting continuously
        reqData  = 32'h13121110;
        reqValid = 4'b1111;
        nready   = 0;
        dsave    = done_cnt;
        for (int i = 0; i < 1000 && nready < 5; i++) begin
            @(negedge clk);
            if (reqReady != '0) begin
                if (nready == 0) check("rr_first_winner", 32'(reqReady), 32'h1);
                nready++;
            end
        end
        reqValid = '0;
        for (int i = 0; i < 400 && sent_q.size() < 5; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("rr_byte0", 32'(sent_q[0]), 32'h10);
        check("rr_byte1", 32'(sent_q[1]), 32'h11);
        check("rr_byte2", 32'(sent_q[2]), 32'h12);
        check("rr_byte3", 32'(sent_q[3]), 32'h13);
        check("rr_byte4", 32'(sent_q[4]), 32'h10);
        check("rr_done_count", 32'(done_cnt - dsave), 32'd5);
        sent_q.delete();

        // Stuck transmitter: watchdog
        uart_dead = 1'b1;
        dsave     = done_cnt;
        reqValid  = 4'b0110;
        @(negedge clk);
        check("wd_ready", 32'(reqReady), 32'h2);
        reqValid = 4'b0100;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (reqErr != '0) break;
            if (txStart) cnt++;
        end
        check("wd_start_cycles", 32'(cnt),     32'd16);
        check("wd_err",          32'(reqErr),  32'h2);
        check("wd_start_off",    32'(txStart), 32'h0);
        check("wd_no_done",      32'(done_cnt), 32'(dsave));
        @(negedge clk);
        check("wd_next_grant", 32'(grant),    32'h4);
        check("wd_next_ready", 32'(reqReady), 32'h4);
        check("wd_err_pulse",  32'(reqErr),   32'h0);
        reqValid  = '0;
        uart_dead = 1'b0;
        wait_done(4'b0100, "wd_next_done");
        for (int i = 0; i < 400 && sent_q.size() < 1; i++) @(negedge clk);
        check("wd_next_byte", 32'(sent_q[0]), 32'h12);
        sent_q.delete();
        repeat (3) @(negedge clk);

        // Packet of two bytes from requester 2 while requester 0 waits
        reqValid       = 4'b0100;
        reqData[23:16] = 8'hAA;
        reqLast        = 4'b0000;
        @(negedge clk);
        check("lock_first_ready", 32'(reqReady), 32'h4);
        reqData[23:16] = 8'hBB;
        reqLast[2]     = 1'b1;
        reqData[7:0]   = 8'h5A;
        reqValid       = 4'b0101;
        for (int i = 0; i < 600 && sent_q.size() < 3; i++) begin
            @(negedge clk);
            if (reqReady[0]) reqValid[0] = 1'b0;
            if (reqReady[2]) reqValid[2] = 1'b0;
        end
`ifdef UART_ARB_LOCK_EN
        exp_b1 = 8'hBB;
        exp_b2 = 8'h5A;
`else
        exp_b1 = 8'h5A;
        exp_b2 = 8'hBB;
`endif
        check("pkt_byte0", 32'(sent_q[0]), 32'hAA);
        check("pkt_byte1", 32'(sent_q[1]), 32'(exp_b1));
        check("pkt_byte2", 32'(sent_q[2]), 32'(exp_b2));
        repeat (3) @(negedge clk);
        check("final_idle", 32'(arbIdle), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
